// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin arbiter that lets NREQ requesters share a single I2C driver.
// Each granted transaction is handed to the driver, and the driver's busy handshake is
// tracked. A watchdog aborts a transaction when the driver never accepts it or never
// finishes it.
//
// Ports
//   clk, rst_n            system clock; synchronous active-low reset
//   req[NREQ]             level request per requester, held until its done pulse
//   req_rw[NREQ]          direction per requester (1 = read)
//   req_addr[7*NREQ]      packed 7-bit slave addresses
//   req_wdata[8*NREQ]     packed write bytes
//   gnt[NREQ]             one-hot owner of the current transaction, zero when idle
//   done[NREQ]            one-cycle completion pulse on the owner's bit
//   err                   1 = watchdog abort (valid while done is nonzero)
//   rdata[8]              read byte (valid while done is nonzero)
//   drv_start             one-cycle start pulse to the driver
//   drv_rw/addr/wdata     transaction fields latched at arbitration
//   drv_busy              driver busy
//   drv_rdata[8]          driver read byte, sampled when busy falls
module i2c_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned TMO_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_rw,
    input  logic [7*NREQ-1:0]    req_addr,
    input  logic [8*NREQ-1:0]    req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic [7:0]           rdata,
    output logic                 drv_start,
    output logic                 drv_rw,
    output logic [6:0]           drv_addr,
    output logic [7:0]           drv_wdata,
    input  logic                 drv_busy,
    input  logic [7:0]           drv_rdata
);

    localparam int unsigned IDX_W = $clog2(NREQ);
    // Timeout fires when the count reaches 2^TMO_W-1, i.e. when incrementing from this value.
    localparam logic [TMO_W-1:0] WD_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NREQ - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitAcc,
        StRun,
        StDone
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   owner_q;
    logic [TMO_W-1:0]   wd_q;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;

    // First active request at or above ptr_q, wrapping to index 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (!win_found && req[(int'(ptr_q) + k) % int'(NREQ)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((int'(ptr_q) + k) % int'(NREQ));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            owner_q   <= '0;
            wd_q      <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= 1'b0;
            rdata     <= 8'h00;
            drv_start <= 1'b0;
            drv_rw    <= 1'b0;
            drv_addr  <= 7'h00;
            drv_wdata <= 8'h00;
        end else begin
            drv_start <= 1'b0;
            done      <= '0;
            unique case (state_q)
                StIdle: begin
                    // A busy driver belongs to someone else (or is still winding down).
                    if (win_found && !drv_busy) begin
                        owner_q   <= win_idx;
                        gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                        drv_rw    <= req_rw[win_idx];
                        drv_addr  <= req_addr[7*int'(win_idx) +: 7];
                        drv_wdata <= req_wdata[8*int'(win_idx) +: 8];
                        drv_start <= 1'b1;
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    wd_q    <= '0;
                    state_q <= StWaitAcc;
                end
                StWaitAcc: begin
                    if (drv_busy) begin
                        wd_q    <= '0;
                        state_q <= StRun;
                    end else if (wd_q == WD_LAST) begin
                        wd_q    <= wd_q + 1'b1;
                        done    <= gnt;
                        err     <= 1'b1;
                        rdata   <= 8'h00;
                        state_q <= StDone;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                StRun: begin
                    // Completion wins over a timeout landing on the same edge.
                    if (!drv_busy) begin
                        done    <= gnt;
                        err     <= 1'b0;
                        rdata   <= drv_rw ? drv_rdata : 8'h00;
                        state_q <= StDone;
                    end else if (wd_q == WD_LAST) begin
                        wd_q    <= wd_q + 1'b1;
                        done    <= gnt;
                        err     <= 1'b1;
                        rdata   <= 8'h00;
                        state_q <= StDone;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                StDone: begin
                    gnt     <= '0;
                    ptr_q   <= (owner_q == IDX_MAX) ? '0 : owner_q + 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
module tb_i2c_arbiter;

    localparam int NREQ  = 4;
    localparam int TMO_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_rw;
    logic [7*NREQ-1:0] req_addr;
    logic [8*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              err;
    logic [7:0]        rdata;
    logic              drv_start;
    logic              drv_rw;
    logic [6:0]        drv_addr;
    logic [7:0]        drv_wdata;
    logic              drv_busy;
    logic [7:0]        drv_rdata;

    logic              model_busy;
    logic              force_busy;
    assign drv_busy = model_busy | force_busy;

    // Driver model configuration
    int                cfg_delay;
    int                cfg_len;
    logic              cfg_hang;
    logic [7:0]        cfg_rd;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic            rw;
        logic [6:0]      addr;
        logic [7:0]      wdata;
    } iss_t;

    typedef struct packed {
        logic [NREQ-1:0] done;
        logic            err;
        logic [7:0]      rdata;
    } dn_t;

    iss_t iq[$];
    dn_t  dq[$];

    i2c_arbiter #(
        .NREQ  (NREQ),
        .TMO_W (TMO_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .drv_start (drv_start),
        .drv_rw    (drv_rw),
        .drv_addr  (drv_addr),
        .drv_wdata (drv_wdata),
        .drv_busy  (drv_busy),
        .drv_rdata (drv_rdata)
    );

    always #5 clk = ~clk;

    // I2C driver model: busy rises cfg_delay cycles after start, stays cfg_len cycles.
    initial begin
        model_busy = 1'b0;
        drv_rdata  = 8'h00;
        forever begin
            @(negedge clk);
            if (drv_start === 1'b1 && !cfg_hang) begin
                repeat (cfg_delay) @(negedge clk);
                model_busy = 1'b1;
                repeat (cfg_len) @(negedge clk);
                drv_rdata  = cfg_rd;
                model_busy = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic rw, input logic [6:0] a, input logic [7:0] d);
        req_rw[i]            = rw;
        req_addr[7*i +: 7]   = a;
        req_wdata[8*i +: 8]  = d;
    endtask

    task automatic wait_start(input int budget, output int lat);
        lat = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (drv_start === 1'b1) begin
                lat = c;
                break;
            end
        end
        check("start_seen", 32'(lat != 0), 32'd1);
    endtask

    task automatic wait_dones(input int n, input int budget, output int cyc);
        int seen;
        seen = 0;
        cyc  = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (done !== '0) begin
                seen++;
                cyc = c;
            end
            if (seen == n) break;
        end
        check("done_seen", 32'(seen), 32'(n));
    endtask

    int lat;
    int cyc;
    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_n      = 1'b0;
        req        = '0;
        req_rw     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        force_busy = 1'b0;
        cfg_delay  = 1;
        cfg_len    = 3;
        cfg_hang   = 1'b0;
        cfg_rd     = 8'hFF;

        // Scoreboard monitor: pops an expectation whenever the DUT presents start or done.
        fork
            begin
                iss_t ie;
                dn_t  de;
                forever begin
                    @(negedge clk);
                    check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
                    if (drv_start === 1'b1) begin
                        if (iq.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_start: got start with gnt=%0h, want none", gnt);
                        end else begin
                            ie = iq.pop_front();
                            check("issue_gnt", 32'(gnt), 32'(ie.gnt));
                            check("issue_rw", 32'(drv_rw), 32'(ie.rw));
                            check("issue_addr", 32'(drv_addr), 32'(ie.addr));
                            check("issue_wdata", 32'(drv_wdata), 32'(ie.wdata));
                        end
                    end
                    if (done !== '0) begin
                        check("done_on_gnt", 32'(done), 32'(gnt));
                        if (dq.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_done: got done=%0h, want none", done);
                        end else begin
                            de = dq.pop_front();
                            check("done_vec", 32'(done), 32'(de.done));
                            check("done_err", 32'(err), 32'(de.err));
                            check("done_rdata", 32'(rdata), 32'(de.rdata));
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_start", 32'(drv_start), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_drv_addr", 32'(drv_addr), 32'h0);
        check("rst_drv_wdata", 32'(drv_wdata), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // All four requesting: grant order 0,1,2,3,0 with 2-cycle done-to-start spacing.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 7'(16 + i), 8'(192 + i));
        for (int k = 0; k < 5; k++) begin
            iq.push_back(iss_t'{gnt: 4'(1 << order[k]), rw: 1'b0,
                                addr: 7'(16 + order[k]), wdata: 8'(192 + order[k])});
            dq.push_back(dn_t'{done: 4'(1 << order[k]), err: 1'b0, rdata: 8'h00});
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_start(20, lat);
            check("start_latency", 32'(lat), (k == 0) ? 32'd1 : 32'd2);
            wait_dones(1, 20, cyc);
            check("rr_txn_cycles", 32'(cyc), 32'd5);
        end
        req = '0;
        repeat (2) @(negedge clk);

        // Single write from requester 0; fields changed and req dropped after grant.
        set_req(0, 1'b0, 7'h50, 8'hA5);
        iq.push_back(iss_t'{gnt: 4'b0001, rw: 1'b0, addr: 7'h50, wdata: 8'hA5});
        dq.push_back(dn_t'{done: 4'b0001, err: 1'b0, rdata: 8'h00});
        cfg_delay = 2;
        cfg_len   = 10;
        req = 4'b0001;
        wait_start(20, lat);
        check("wr_start_latency", 32'(lat), 32'd1);
        set_req(0, 1'b1, 7'h11, 8'h22);
        req = '0;
        wait_dones(1, 40, cyc);
        check("wr_txn_cycles", 32'(cyc), 32'd13);
        check("wr_hold_addr", 32'(drv_addr), 32'h50);
        check("wr_hold_wdata", 32'(drv_wdata), 32'hA5);
        check("wr_hold_rw", 32'(drv_rw), 32'h0);
        repeat (2) @(negedge clk);

        // Read from requester 2.
        set_req(2, 1'b1, 7'h3C, 8'h99);
        cfg_rd    = 8'h7E;
        cfg_delay = 1;
        cfg_len   = 4;
        iq.push_back(iss_t'{gnt: 4'b0100, rw: 1'b1, addr: 7'h3C, wdata: 8'h99});
        dq.push_back(dn_t'{done: 4'b0100, err: 1'b0, rdata: 8'h7E});
        req = 4'b0100;
        wait_start(20, lat);
        check("rd_start_latency", 32'(lat), 32'd1);
        req = '0;
        wait_dones(1, 30, cyc);
        check("rd_txn_cycles", 32'(cyc), 32'd6);
        repeat (2) @(negedge clk);

        // Driver never accepts: watchdog abort after 15 WAIT_ACC cycles (leaves ptr at 3).
        cfg_hang = 1'b1;
        iq.push_back(iss_t'{gnt: 4'b0100, rw: 1'b1, addr: 7'h3C, wdata: 8'h99});
        dq.push_back(dn_t'{done: 4'b0100, err: 1'b1, rdata: 8'h00});
        req = 4'b0100;
        wait_start(20, lat);
        req = '0;
        wait_dones(1, 40, cyc);
        check("tmo_cycles", 32'(cyc), 32'd16);
        cfg_hang = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during RUN: silent abort, then arbitration restarts from index 0.
        set_req(0, 1'b0, 7'h50, 8'hA5);
        cfg_delay = 1;
        cfg_len   = 12;
        iq.push_back(iss_t'{gnt: 4'b0001, rw: 1'b0, addr: 7'h50, wdata: 8'hA5});
        req = 4'b0001;
        wait_start(20, lat);
        req = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        check("mid_rst_done", 32'(done), 32'h0);
        check("mid_rst_start", 32'(drv_start), 32'h0);
        check("mid_rst_err", 32'(err), 32'h0);
        check("mid_rst_rdata", 32'(rdata), 32'h0);
        check("mid_rst_rw", 32'(drv_rw), 32'h0);
        check("mid_rst_addr", 32'(drv_addr), 32'h0);
        check("mid_rst_wdata", 32'(drv_wdata), 32'h0);
        rst_n = 1'b1;
        set_req(1, 1'b0, 7'h21, 8'h31);
        set_req(3, 1'b1, 7'h23, 8'h33);
        iq.push_back(iss_t'{gnt: 4'b0010, rw: 1'b0, addr: 7'h21, wdata: 8'h31});
        dq.push_back(dn_t'{done: 4'b0010, err: 1'b0, rdata: 8'h00});
        req = 4'b1010;
        wait_start(40, lat);
        req = '0;
        cfg_len = 12;
        wait_dones(1, 30, cyc);
        check("post_rst_txn_cycles", 32'(cyc), 32'd14);
        repeat (2) @(negedge clk);

        // Driver busy in IDLE blocks arbitration until it drops.
        force_busy = 1'b1;
        req = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("blocked_gnt", 32'(gnt), 32'h0);
            check("blocked_start", 32'(drv_start), 32'h0);
        end
        cfg_delay = 1;
        cfg_len   = 2;
        iq.push_back(iss_t'{gnt: 4'b0001, rw: 1'b0, addr: 7'h50, wdata: 8'hA5});
        dq.push_back(dn_t'{done: 4'b0001, err: 1'b0, rdata: 8'h00});
        force_busy = 1'b0;
        wait_start(5, lat);
        check("unblock_latency", 32'(lat), 32'd1);
        req = '0;
        wait_dones(1, 20, cyc);
        check("unblock_txn_cycles", 32'(cyc), 32'd4);

        repeat (3) @(negedge clk);
        check("issue_q_drained", 32'(iq.size()), 32'd0);
        check("done_q_drained", 32'(dq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
